clmi_fetch_ctl: RTL and testbench
=================================

Name: clmi_fetch_ctl

Overview:
- Instruction-fetch controller directly upstream of the SF-stage instruction register.
- Runs the request/acknowledge handshake with instruction memory.
- Drives the one-hot next-InstSF select (ZERO/LOAD/HOLD), the register hold, and the INST_I data into that register.
- Contains a 1-entry skid buffer for data returned while the pipeline is stalled, plus redirect/flush handling.

Parameters:
- WDOG_MAX, 255, cycles an unacknowledged request may stay pending before FETCH_ERR fires; counter width is 8 bits.

Ports:
- SYSCLK  input  1  clock.
- RESET_D1_R_N  input  1  reset, asynchronous assert, active-low.
- PIPE_STALL  input  1  downstream pipeline stall.
- CP0_REDIRECT  input  1  flush/redirect (exception, branch, ERET); kills in-flight fetch.
- IMEM_ACK  input  1  read data valid this cycle.
- IMEM_RDATA  input  32  instruction word from memory.
- IMEM_REQ  output  1  fetch request.
- INST_I  output  32  instruction to the SF register.
- CLMI_SELINST_S_P  output  `CLMI_SEL_INST_HI+1  one-hot next-InstSF select.
- CLMI_RHOLD  output  1  register hold.
- FETCH_VALID_S_R  output  1  SF register holds a real (non-bubble) instruction.
- FETCH_ERR  output  1  one-cycle watchdog timeout pulse.

Behaviour:
- One clock; reset is asynchronous and active-low on RESET_D1_R_N.
- Reset values: state IDLE, IMEM_REQ=0, select=ZERO, CLMI_RHOLD=0, FETCH_VALID_S_R=0, buffer invalid, watchdog=0, FETCH_ERR=0.
- States:
  - IDLE: one cycle after reset release; always goes to REQ.
  - REQ: request outstanding.
  - BUF: skid buffer full.
  - DROP: outstanding request must be discarded.
- IMEM_REQ=1 in REQ and DROP. Once raised it is held until IMEM_ACK; a request is never withdrawn.
- CLMI_RHOLD = PIPE_STALL (combinational).
- Select is combinational and exactly one-hot every cycle. Priority order:
  1. CP0_REDIRECT=1:
     - Select=ZERO and the buffer is invalidated.
     - From REQ without ACK: go to DROP.
     - From REQ with ACK: data is discarded and the state stays REQ.
     - From BUF: go to REQ.
  2. PIPE_STALL=1: select=HOLD.
     - REQ with ACK: IMEM_RDATA is captured into the buffer; next state BUF; IMEM_REQ drops next cycle.
  3. REQ, ACK, no stall:
     - select=LOAD, INST_I=IMEM_RDATA.
     - Stay in REQ with IMEM_REQ still high (back-to-back fetch, zero bubbles).
  4. REQ, no ACK, no stall: select=ZERO (NOP bubble).
  5. BUF, no stall:
     - select=LOAD, INST_I=buffer.
     - Go to REQ; IMEM_REQ is raised the same cycle.
  6. DROP:
     - Select=ZERO when not stalled, HOLD when stalled.
     - ACK data is discarded; then go to REQ.
     - A further redirect while in DROP stays in DROP.
- INST_I = IMEM_RDATA except in BUF, where it is the buffer. When not LOAD it is don't-care but stable.
- FETCH_VALID_S_R updates unless PIPE_STALL: set on LOAD, cleared on ZERO.
- Fetch latency: request to LOAD in the ACK cycle; INST_S_R is valid the following edge.
- Reset mid-transfer: everything returns to reset values immediately. A late ACK after reset release is ignored because IDLE ignores ACK.

Optional Feature:
- Macro: CLMI_FETCH_WDOG_EN.
- Defined:
  - 8-bit counter increments each cycle with IMEM_REQ=1 and IMEM_ACK=0; it clears on ACK or on leaving REQ/DROP.
  - On reaching WDOG_MAX, FETCH_ERR=1 for one cycle, the counter clears, and the state is unchanged.
- Undefined: no counter; FETCH_ERR tied 0.

Decomposition:
- CLMI_SEL_INST_ZERO_POS/LOAD_POS/HOLD_POS and CLMI_SEL_INST_HI stay in the shared core symbols include.
- New state encodings CLMI_FST_IDLE/REQ/BUF/DROP go in the same include.
- No sub-module needed. The skid buffer is 32 bits plus a valid flag, inline.

Test Plan:
- Reset release, ACK on every cycle from the first request, no stall -> select ZERO, ZERO, then LOAD each cycle; INST_I follows IMEM_RDATA 0x24010001, 0x24020002; IMEM_REQ stays high.
- ACK with 0x8C430004 while PIPE_STALL=1 for 3 cycles -> HOLD for 3 cycles, IMEM_REQ=0 from the next cycle; on stall release LOAD with INST_I=0x8C430004 and IMEM_REQ=1 the same cycle.
- CP0_REDIRECT while a request is pending, ACK 2 cycles later with 0xDEADBEEF -> select ZERO throughout, 0xDEADBEEF is never LOADed, a new request follows.
- Redirect coincident with ACK and with PIPE_STALL -> ZERO wins, buffer stays invalid, no LOAD follows.
- Assert reset while in BUF -> next cycle all outputs at reset values; the buffered word is never LOADed.
- With CLMI_FETCH_WDOG_EN and WDOG_MAX=4: no ACK for 10 cycles -> FETCH_ERR pulses on the cycles the counter reaches 4 (twice); without the macro FETCH_ERR stays 0.

Source files
------------

// File: rtl/clmi_fetch_ctl_pkg.sv
// Shared CLMI core symbols (InstSF select bit positions, fetch state codes)
// and the types used by the instruction-fetch controller.
`ifndef CLMI_CORE_SYMS
`define CLMI_CORE_SYMS
`define CLMI_SEL_INST_ZERO_POS 0
`define CLMI_SEL_INST_LOAD_POS 1
`define CLMI_SEL_INST_HOLD_POS 2
`define CLMI_SEL_INST_HI       2
`define CLMI_FST_IDLE          2'd0
`define CLMI_FST_REQ           2'd1
`define CLMI_FST_BUF           2'd2
`define CLMI_FST_DROP          2'd3
`endif

package clmi_fetch_ctl_pkg;

   localparam int SEL_W = `CLMI_SEL_INST_HI + 1;

   localparam logic [SEL_W-1:0] SEL_ZERO = SEL_W'(1) << `CLMI_SEL_INST_ZERO_POS;
   localparam logic [SEL_W-1:0] SEL_LOAD = SEL_W'(1) << `CLMI_SEL_INST_LOAD_POS;
   localparam logic [SEL_W-1:0] SEL_HOLD = SEL_W'(1) << `CLMI_SEL_INST_HOLD_POS;

   localparam int WDOG_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = `CLMI_FST_IDLE,
      ST_REQ  = `CLMI_FST_REQ,
      ST_BUF  = `CLMI_FST_BUF,
      ST_DROP = `CLMI_FST_DROP
   } fetch_state_t;

endpackage

// File: rtl/clmi_fetch_ctl.sv
// Instruction-fetch controller feeding the SF-stage instruction register, with a
// 1-entry skid buffer and redirect handling. Optional watchdog: CLMI_FETCH_WDOG_EN.
// Handshake: IMEM_REQ, once raised, stays high until the cycle IMEM_ACK is seen;
// IMEM_ACK marks IMEM_RDATA valid in that same cycle, and the request is never withdrawn.
module clmi_fetch_ctl
   import clmi_fetch_ctl_pkg::*;
#(
   parameter int unsigned WDOG_MAX = 255
) (
   input  logic                        SYSCLK,
   input  logic                        RESET_D1_R_N,
   input  logic                        PIPE_STALL,
   input  logic                        CP0_REDIRECT,
   input  logic                        IMEM_ACK,
   input  logic [31:0]                 IMEM_RDATA,
   output logic                        IMEM_REQ,
   output logic [31:0]                 INST_I,
   output logic [`CLMI_SEL_INST_HI:0]  CLMI_SELINST_S_P,
   output logic                        CLMI_RHOLD,
   output logic                        FETCH_VALID_S_R,
   output logic                        FETCH_ERR,
   output fetch_state_t                dbg_state
);

   if (WDOG_MAX < 1 || WDOG_MAX > 255) begin : g_wdog_range
      $error("WDOG_MAX must fit the 8-bit watchdog counter (1..255)");
   end

   fetch_state_t      state, state_nxt;
   logic [SEL_W-1:0]  sel;
   logic              capture;
   logic              buf_clr;
   logic [31:0]       buf_data;
   logic              buf_valid;

   // The next-state decode mirrors the select priority: redirect, stall, then data.
   always_comb begin
      state_nxt = state;
      sel       = SEL_ZERO;
      capture   = 1'b0;
      buf_clr   = CP0_REDIRECT;
      case (state)
         ST_IDLE: state_nxt = ST_REQ;
         ST_REQ: begin
            if (CP0_REDIRECT) begin
               if (!IMEM_ACK) state_nxt = ST_DROP;
            end else if (PIPE_STALL) begin
               sel = SEL_HOLD;
               if (IMEM_ACK) begin
                  capture   = 1'b1;
                  state_nxt = ST_BUF;
               end
            end else if (IMEM_ACK) begin
               sel = SEL_LOAD;
            end
         end
         ST_BUF: begin
            if (CP0_REDIRECT) begin
               state_nxt = ST_REQ;
            end else if (PIPE_STALL) begin
               sel = SEL_HOLD;
            end else begin
               sel       = SEL_LOAD;
               buf_clr   = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         ST_DROP: begin
            if (!CP0_REDIRECT) begin
               if (PIPE_STALL) sel = SEL_HOLD;
               if (IMEM_ACK) state_nxt = ST_REQ;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge SYSCLK or negedge RESET_D1_R_N) begin
      if (!RESET_D1_R_N) begin
         state           <= ST_IDLE;
         buf_data        <= '0;
         buf_valid       <= 1'b0;
         FETCH_VALID_S_R <= 1'b0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            buf_data  <= IMEM_RDATA;
            buf_valid <= 1'b1;
         end else if (buf_clr) begin
            buf_valid <= 1'b0;
         end
         if (!PIPE_STALL) begin
            if (sel == SEL_LOAD)      FETCH_VALID_S_R <= 1'b1;
            else if (sel == SEL_ZERO) FETCH_VALID_S_R <= 1'b0;
         end
      end
   end

   // Leaving BUF re-raises the request in the same cycle so the refill starts without a bubble.
   assign IMEM_REQ = (state == ST_REQ) || (state == ST_DROP) ||
                     ((state == ST_BUF) && !CP0_REDIRECT && !PIPE_STALL);
   assign INST_I           = buf_valid ? buf_data : IMEM_RDATA;
   assign CLMI_SELINST_S_P = sel;
   assign CLMI_RHOLD       = PIPE_STALL;
   assign dbg_state        = state;

`ifdef CLMI_FETCH_WDOG_EN
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);

   logic [WDOG_W-1:0] wdog_cnt;
   logic              wdog_err;
   logic              waiting;

   assign waiting = (state == ST_REQ) || (state == ST_DROP);

   always_ff @(posedge SYSCLK or negedge RESET_D1_R_N) begin
      if (!RESET_D1_R_N) begin
         wdog_cnt <= '0;
         wdog_err <= 1'b0;
      end else begin
         wdog_err <= 1'b0;
         if (waiting && !IMEM_ACK) begin
            if (wdog_cnt == WDOG_LAST) begin
               wdog_cnt <= '0;
               wdog_err <= 1'b1;
            end else begin
               wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end
         end else begin
            wdog_cnt <= '0;
         end
      end
   end

   assign FETCH_ERR = wdog_err;
`else
   assign FETCH_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_clmi_fetch_ctl.sv
// Directed bench for clmi_fetch_ctl: each cycle drives inputs at the falling edge
// and compares outputs against hand-computed expectations 1 ns later.
module tb_clmi_fetch_ctl;
   import clmi_fetch_ctl_pkg::*;

   localparam logic [2:0]  E_ZERO = 3'b001;
   localparam logic [2:0]  E_LOAD = 3'b010;
   localparam logic [2:0]  E_HOLD = 3'b100;
   localparam logic [1:0]  E_IDLE = 2'd0;
   localparam logic [1:0]  E_REQ  = 2'd1;
   localparam logic [1:0]  E_BUF  = 2'd2;
   localparam logic [1:0]  E_DROP = 2'd3;

   logic         clk;
   logic         rst_n;
   logic         pipe_stall;
   logic         cp0_redirect;
   logic         imem_ack;
   logic [31:0]  imem_rdata;
   logic         imem_req;
   logic [31:0]  inst_i;
   logic [2:0]   sel;
   logic         rhold;
   logic         fetch_valid;
   logic         fetch_err;
   fetch_state_t dbg_state;

   int checks = 0;
   int errors = 0;

   clmi_fetch_ctl #(.WDOG_MAX(4)) dut (
      .SYSCLK           (clk),
      .RESET_D1_R_N     (rst_n),
      .PIPE_STALL       (pipe_stall),
      .CP0_REDIRECT     (cp0_redirect),
      .IMEM_ACK         (imem_ack),
      .IMEM_RDATA       (imem_rdata),
      .IMEM_REQ         (imem_req),
      .INST_I           (inst_i),
      .CLMI_SELINST_S_P (sel),
      .CLMI_RHOLD       (rhold),
      .FETCH_VALID_S_R  (fetch_valid),
      .FETCH_ERR        (fetch_err),
      .dbg_state        (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic stall, input logic redirect, input logic ack,
                        input logic [31:0] rdata);
      @(negedge clk);
      pipe_stall   = stall;
      cp0_redirect = redirect;
      imem_ack     = ack;
      imem_rdata   = rdata;
      #1;
   endtask

   task automatic expect_cyc(input string tag, input logic req, input logic [2:0] exp_sel,
                             input logic [31:0] inst, input logic fv, input logic [1:0] st,
                             input logic err);
      check({tag, "/req"},   32'(imem_req),    32'(req));
      check({tag, "/sel"},   32'(sel),         32'(exp_sel));
      if (exp_sel == E_LOAD) check({tag, "/inst"}, inst_i, inst);
      check({tag, "/fv"},    32'(fetch_valid), 32'(fv));
      check({tag, "/state"}, 32'(dbg_state),   32'(st));
      check({tag, "/hold"},  32'(rhold),       32'(pipe_stall));
      check({tag, "/err"},   32'(fetch_err),   32'(err));
   endtask

   initial begin
      rst_n        = 1'b0;
      pipe_stall   = 1'b0;
      cp0_redirect = 1'b0;
      imem_ack     = 1'b0;
      imem_rdata   = '0;
      repeat (2) @(negedge clk);
      #1;
      expect_cyc("reset", 1'b0, E_ZERO, 32'h0, 1'b0, E_IDLE, 1'b0);

      // Back-to-back fetch with ACK every cycle.
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      expect_cyc("idle", 1'b0, E_ZERO, 32'h0, 1'b0, E_IDLE, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'h2401_0001);
      expect_cyc("b2b0", 1'b1, E_LOAD, 32'h2401_0001, 1'b0, E_REQ, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'h2402_0002);
      expect_cyc("b2b1", 1'b1, E_LOAD, 32'h2402_0002, 1'b1, E_REQ, 1'b0);

      // ACK under a 3-cycle stall lands in the skid buffer.
      drive(1'b1, 1'b0, 1'b1, 32'h8C43_0004);
      expect_cyc("skid0", 1'b1, E_HOLD, 32'h0, 1'b1, E_REQ, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      expect_cyc("skid1", 1'b0, E_HOLD, 32'h0, 1'b1, E_BUF, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      expect_cyc("skid2", 1'b0, E_HOLD, 32'h0, 1'b1, E_BUF, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      expect_cyc("skid_rel", 1'b1, E_LOAD, 32'h8C43_0004, 1'b1, E_BUF, 1'b0);

      // Redirect with a pending request; the late ACK data is discarded.
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      expect_cyc("redir0", 1'b1, E_ZERO, 32'h0, 1'b1, E_REQ, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      expect_cyc("drop0", 1'b1, E_ZERO, 32'h0, 1'b0, E_DROP, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      expect_cyc("drop_ack", 1'b1, E_ZERO, 32'h0, 1'b0, E_DROP, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      expect_cyc("refetch", 1'b1, E_ZERO, 32'h0, 1'b0, E_REQ, 1'b0);

      // Redirect coincident with ACK and stall: ZERO wins, nothing captured.
      drive(1'b1, 1'b1, 1'b1, 32'h1111_2222);
      expect_cyc("rsa", 1'b1, E_ZERO, 32'h0, 1'b0, E_REQ, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      expect_cyc("rsa_after", 1'b1, E_ZERO, 32'h0, 1'b0, E_REQ, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'h3333_4444);
      expect_cyc("rsa_load", 1'b1, E_LOAD, 32'h3333_4444, 1'b0, E_REQ, 1'b0);

      // Redirect while the buffer is full throws the buffered word away.
      drive(1'b1, 1'b0, 1'b1, 32'h5555_6666);
      expect_cyc("bufr0", 1'b1, E_HOLD, 32'h0, 1'b1, E_REQ, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      expect_cyc("bufr1", 1'b0, E_ZERO, 32'h0, 1'b1, E_BUF, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'h7777_8888);
      expect_cyc("bufr2", 1'b1, E_LOAD, 32'h7777_8888, 1'b0, E_REQ, 1'b0);

      // Reset while the buffer is full.
      drive(1'b1, 1'b0, 1'b1, 32'hCAFE_F00D);
      expect_cyc("rstbuf0", 1'b1, E_HOLD, 32'h0, 1'b1, E_REQ, 1'b0);
      @(negedge clk);
      rst_n      = 1'b0;
      pipe_stall = 1'b0;
      imem_ack   = 1'b0;
      #1;
      expect_cyc("rstbuf1", 1'b0, E_ZERO, 32'h0, 1'b0, E_IDLE, 1'b0);
      @(negedge clk);
      rst_n      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      #1;
      expect_cyc("rstbuf_idle", 1'b0, E_ZERO, 32'h0, 1'b0, E_IDLE, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'h0000_000F);
      expect_cyc("rstbuf_load", 1'b1, E_LOAD, 32'h0000_000F, 1'b0, E_REQ, 1'b0);

      // Ten cycles without ACK: watchdog (WDOG_MAX=4) fires on cycles 5 and 9.
      for (int k = 1; k <= 10; k++) begin
         logic exp_err;
`ifdef CLMI_FETCH_WDOG_EN
         exp_err = (k == 5) || (k == 9);
`else
         exp_err = 1'b0;
`endif
         drive(1'b0, 1'b0, 1'b0, 32'h0);
         expect_cyc($sformatf("wdog%0d", k), 1'b1, E_ZERO, 32'h0, (k == 1), E_REQ, exp_err);
      end
      drive(1'b0, 1'b0, 1'b1, 32'hABCD_0123);
      expect_cyc("wdog_ack", 1'b1, E_LOAD, 32'hABCD_0123, 1'b0, E_REQ, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
